// File: rtl/drive_mode_ctrl.sv
// Power sequencing, mode selection and motion-command mux for the car simulation.
// Latency: state/enables change one edge after the cause; motion outputs lag the selected command by one cycle.
// Backpressure: none; level-driven inputs are sampled every cycle and outputs are never stalled.
module drive_mode_ctrl #(
    parameter int LONG_PRESS_CYC   = 100_000_000,
    parameter int IDLE_TIMEOUT_CYC = 1_000_000_000,
    parameter int SWITCH_GAP_CYC   = 4,
    parameter int CNT_W            = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_btn,
    input  logic [1:0] mode_sel,
    input  logic [3:0] man_cmd,
    input  logic [3:0] semi_cmd,
    input  logic [3:0] auto_cmd,
    output logic       power,
    output logic       manual_en,
    output logic       semi_en,
    output logic       auto_en,
    output logic       move_fwd,
    output logic       move_bwd,
    output logic       turn_left,
    output logic       turn_right,
    output logic [2:0] ctrl_state
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_MANUAL = 3'd2,
        ST_SEMI   = 3'd3,
        ST_AUTO   = 3'd4,
        ST_SWITCH = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SWITCH_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_nxt;
    logic             arm, arm_nxt;
    logic [1:0]       mode_sel_q;
    logic [3:0]       cmd_q, cmd_nxt;

    state_t           target;
    logic [3:0]       sel_cmd;
    logic [3:0]       safe_cmd;
    logic             mode_chg;
    logic             activity;
    logic             long_press;
    logic             idle_expire;

    // Decode requested mode, pick the live controller's command and resolve opposing requests.
    always_comb begin
        target = ST_IDLE;
        case (mode_sel)
            2'b01:   target = ST_MANUAL;
            2'b10:   target = ST_SEMI;
            2'b11:   target = ST_AUTO;
            default: target = ST_IDLE;
        endcase

        sel_cmd = 4'b0000;
        case (state)
            ST_MANUAL: sel_cmd = man_cmd;
            ST_SEMI:   sel_cmd = semi_cmd;
            ST_AUTO:   sel_cmd = auto_cmd;
            default:   sel_cmd = 4'b0000;
        endcase

        // {fwd,bwd,left,right}: a contradictory pair cancels to neither.
        safe_cmd[3] = sel_cmd[3] & ~sel_cmd[2];
        safe_cmd[2] = sel_cmd[2] & ~sel_cmd[3];
        safe_cmd[1] = sel_cmd[1] & ~sel_cmd[0];
        safe_cmd[0] = sel_cmd[0] & ~sel_cmd[1];

        mode_chg    = (mode_sel != mode_sel_q);
        activity    = (|sel_cmd) | power_btn | mode_chg;
        long_press  = power_btn && (hold_cnt >= LONG_LAST);
        idle_expire = !activity && (idle_cnt >= IDLE_LAST);
    end

    // Next-state, counter and arm-flag logic; forced power-off overrides everything.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        hold_nxt  = '0;
        idle_nxt  = '0;
        arm_nxt   = arm;
        cmd_nxt   = 4'b0000;

        case (state)
            ST_OFF: begin
                if (power_btn && arm) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE, ST_MANUAL, ST_SEMI, ST_AUTO: begin
                if (target != state) begin
                    state_nxt = ST_SWITCH;
                    gap_nxt   = GAP_LAST;
                end
            end
            ST_SWITCH: begin
                // A new selection restarts the blanking so the gap follows the last change.
                if (mode_chg) begin
                    gap_nxt = GAP_LAST;
                end else if (gap_cnt == '0) begin
                    state_nxt = target;
                end else begin
                    gap_nxt = gap_cnt - CNT_ONE;
                end
            end
            default: state_nxt = ST_OFF;
        endcase

        if (state != ST_OFF) begin
            if (power_btn) begin
                hold_nxt = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_ONE;
            end
            if (!activity) begin
                idle_nxt = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + CNT_ONE;
            end
            if (long_press || idle_expire) begin
                state_nxt = ST_OFF;
            end
        end

        if (state_nxt == ST_OFF) begin
            hold_nxt = '0;
            idle_nxt = '0;
            gap_nxt  = '0;
        end

        // Arm only after a release, so a button held through power-off cannot re-power.
        if (!power_btn) begin
            arm_nxt = 1'b1;
        end else if (state_nxt != state && (state == ST_OFF || state_nxt == ST_OFF)) begin
            arm_nxt = 1'b0;
        end

        // Capture commands only while staying in the same driving mode; any transition blanks them.
        if (state_nxt == state) begin
            cmd_nxt = safe_cmd;
        end
    end

    // State and datapath registers with asynchronous reset to the powered-off condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            hold_cnt   <= '0;
            idle_cnt   <= '0;
            gap_cnt    <= '0;
            arm        <= 1'b0;
            mode_sel_q <= 2'b00;
            cmd_q      <= 4'b0000;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            idle_cnt   <= idle_nxt;
            gap_cnt    <= gap_nxt;
            arm        <= arm_nxt;
            mode_sel_q <= mode_sel;
            cmd_q      <= cmd_nxt;
        end
    end

    // Outputs decoded from the registered state and command register.
    always_comb begin
        power      = (state != ST_OFF);
        manual_en  = (state == ST_MANUAL);
        semi_en    = (state == ST_SEMI);
        auto_en    = (state == ST_AUTO);
        move_fwd   = cmd_q[3];
        move_bwd   = cmd_q[2];
        turn_left  = cmd_q[1];
        turn_right = cmd_q[0];
        ctrl_state = state;
    end

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// Directed bench for drive_mode_ctrl with short timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Expected values are hand-derived constants per step.
module tb_drive_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       power_btn;
    logic [1:0] mode_sel;
    logic [3:0] man_cmd;
    logic [3:0] semi_cmd;
    logic [3:0] auto_cmd;
    logic       power;
    logic       manual_en;
    logic       semi_en;
    logic       auto_en;
    logic       move_fwd;
    logic       move_bwd;
    logic       turn_left;
    logic       turn_right;
    logic [2:0] ctrl_state;

    logic [7:0] outs;
    int         passed = 0;
    int         total  = 0;

    drive_mode_ctrl #(
        .LONG_PRESS_CYC  (8),
        .IDLE_TIMEOUT_CYC(20),
        .SWITCH_GAP_CYC  (2),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .power_btn (power_btn),
        .mode_sel  (mode_sel),
        .man_cmd   (man_cmd),
        .semi_cmd  (semi_cmd),
        .auto_cmd  (auto_cmd),
        .power     (power),
        .manual_en (manual_en),
        .semi_en   (semi_en),
        .auto_en   (auto_en),
        .move_fwd  (move_fwd),
        .move_bwd  (move_bwd),
        .turn_left (turn_left),
        .turn_right(turn_right),
        .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    // {power, manual_en, semi_en, auto_en, fwd, bwd, left, right}
    assign outs = {power, manual_en, semi_en, auto_en, move_fwd, move_bwd, turn_left, turn_right};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st, input logic [7:0] o);
        chk({tag, "_state"}, {5'b0, ctrl_state}, {5'b0, st});
        chk({tag, "_outs"}, outs, o);
    endtask

    initial begin
        rst_n     = 1'b0;
        power_btn = 1'b0;
        mode_sel  = 2'b00;
        man_cmd   = 4'b0000;
        semi_cmd  = 4'b0000;
        auto_cmd  = 4'b0000;
        step(2);
        chk_st("reset", 3'd0, 8'b0000_0000);
        rst_n = 1'b1;
        step(1);
        chk_st("post_reset", 3'd0, 8'b0000_0000);

        // 1. short press powers on; 8-cycle hold powers off; held button cannot re-power
        power_btn = 1'b1;
        step(1);
        power_btn = 1'b0;
        chk_st("power_on", 3'd1, 8'b1000_0000);
        step(1);
        power_btn = 1'b1;
        step(7);
        chk_st("hold7", 3'd1, 8'b1000_0000);
        step(1);
        chk_st("hold8_off", 3'd0, 8'b0000_0000);
        step(10);
        chk_st("held_stays_off", 3'd0, 8'b0000_0000);
        power_btn = 1'b0;
        step(1);
        power_btn = 1'b1;
        step(1);
        power_btn = 1'b0;
        chk_st("repress_on", 3'd1, 8'b1000_0000);

        // 2. IDLE -> MANUAL through a 2-cycle blanking gap
        mode_sel = 2'b01;
        step(1);
        chk_st("sw1_gap0", 3'd5, 8'b1000_0000);
        step(1);
        chk_st("sw1_gap1", 3'd5, 8'b1000_0000);
        step(1);
        chk_st("manual", 3'd2, 8'b1100_0000);
        man_cmd = 4'b1000;
        step(1);
        chk_st("man_fwd", 3'd2, 8'b1100_1000);

        // 3. MANUAL -> AUTO; commands blanked, then auto_cmd drives, man_cmd ignored
        mode_sel = 2'b11;
        step(1);
        chk_st("sw2_gap0", 3'd5, 8'b1000_0000);
        step(1);
        chk_st("sw2_gap1", 3'd5, 8'b1000_0000);
        auto_cmd = 4'b0100;
        step(1);
        chk_st("auto_entry", 3'd4, 8'b1001_0000);
        step(1);
        chk_st("auto_bwd", 3'd4, 8'b1001_0100);
        man_cmd = 4'b1111;
        step(1);
        chk_st("auto_ign_man", 3'd4, 8'b1001_0100);
        man_cmd  = 4'b0000;

        // 4. SEMI: opposing pairs cancel, non-conflicting bits pass
        mode_sel = 2'b10;
        auto_cmd = 4'b0000;
        step(3);
        chk_st("semi", 3'd3, 8'b1010_0000);
        semi_cmd = 4'b1111;
        step(1);
        chk_st("semi_all_conflict", 3'd3, 8'b1010_0000);
        semi_cmd = 4'b1010;
        step(1);
        chk_st("semi_fwd_left", 3'd3, 8'b1010_1010);
        semi_cmd = 4'b0000;

        // 5. Inactivity timeout in MANUAL, and a mid-window pulse that keeps it alive
        mode_sel = 2'b01;
        step(3);
        chk_st("manual2", 3'd2, 8'b1100_0000);
        man_cmd = 4'b0001;
        step(1);
        chk_st("man_right", 3'd2, 8'b1100_0001);
        man_cmd = 4'b0000;
        step(19);
        chk_st("idle19_on", 3'd2, 8'b1100_0000);
        step(1);
        chk_st("idle20_off", 3'd0, 8'b0000_0000);

        power_btn = 1'b1;
        step(1);
        power_btn = 1'b0;
        step(3);
        chk_st("manual3", 3'd2, 8'b1100_0000);
        man_cmd = 4'b0001;
        step(1);
        man_cmd = 4'b0000;
        step(14);
        man_cmd = 4'b0001;
        step(1);
        man_cmd = 4'b0000;
        step(10);
        chk_st("kept_alive_25", 3'd2, 8'b1100_0000);
        step(9);
        chk_st("kept_alive_idle19", 3'd2, 8'b1100_0000);
        step(1);
        chk_st("idle_off_again", 3'd0, 8'b0000_0000);

        // 6. Asynchronous reset mid-SWITCH with button held; re-arm needs a release
        power_btn = 1'b1;
        step(1);
        chk_st("on_for_rst", 3'd1, 8'b1000_0000);
        step(1);
        chk_st("switch_for_rst", 3'd5, 8'b1000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_st("async_rst", 3'd0, 8'b0000_0000);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk_st("rst_held_off", 3'd0, 8'b0000_0000);
        power_btn = 1'b0;
        step(1);
        power_btn = 1'b1;
        step(1);
        power_btn = 1'b0;
        chk_st("rearm_on", 3'd1, 8'b1000_0000);
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/drive_mode_ctrl.md
Name: drive_mode_ctrl

Overview:
Top-level sequencer for the car simulation. It owns power on/off (short press on, long press off), plus the automatic power-off on inactivity. It selects exactly one driving controller (manual, semi-auto, auto) and muxes that controller's movement commands onto the shared motion outputs. A blanking gap on every mode change guarantees no overlapping commands.

Parameters:
LONG_PRESS_CYC, 100_000_000, cycles power_btn must be held to power off (1 s @100 MHz)
IDLE_TIMEOUT_CYC, 1_000_000_000, cycles without activity before auto power-off
SWITCH_GAP_CYC, 4, blanking cycles between leaving one mode and entering the next
CNT_W, 30, width of internal counters; must hold IDLE_TIMEOUT_CYC

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
power_btn  in  1  power button level, already synchronised/debounced
mode_sel  in  2  00 none, 01 manual, 10 semi, 11 auto
man_cmd  in  4  manual controller {fwd,bwd,left,right}
semi_cmd  in  4  semi-auto controller {fwd,bwd,left,right}
auto_cmd  in  4  auto controller {fwd,bwd,left,right}
power  out  1  system powered
manual_en  out  1  enable to manual controller
semi_en  out  1  enable to semi-auto controller
auto_en  out  1  enable to auto controller
move_fwd  out  1  shared forward command
move_bwd  out  1  shared backward command
turn_left  out  1  shared left-turn command
turn_right  out  1  shared right-turn command
ctrl_state  out  3  current FSM state, for display

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. State=OFF, all outputs 0, counters 0, arm flag 0.
- States (ctrl_state encoding): OFF=0, IDLE=1, MANUAL=2, SEMI=3, AUTO=4, SWITCH=5.
- Arm flag:
  - Set whenever power_btn=0.
  - Power-on requires a press seen with the arm flag set, so a button still held from a power-off cannot re-power.
- OFF:
  - power_btn=1 with arm=1 -> IDLE next cycle, arm cleared.
  - Otherwise stay in OFF.
- Powered states (IDLE/MANUAL/SEMI/AUTO/SWITCH):
  - power=1.
  - The hold counter increments while power_btn=1 and clears to 0 when power_btn=0.
  - When the hold counter reaches LONG_PRESS_CYC-1 with the button still held -> OFF. This has top priority over every other transition.
- Mode target decode: mode_sel 00->IDLE, 01->MANUAL, 10->SEMI, 11->AUTO.
- IDLE/MANUAL/SEMI/AUTO: if the decoded target differs from the current state -> SWITCH, gap counter loaded with SWITCH_GAP_CYC-1.
- SWITCH:
  - Gap counter decrements; at 0 -> enter the target decoded from mode_sel in that cycle.
  - If mode_sel changes during SWITCH, the gap counter reloads, so the gap is always a full SWITCH_GAP_CYC after the last change.
- Enables are decoded from the registered state:
  - manual_en=1 only in MANUAL, semi_en only in SEMI, auto_en only in AUTO.
  - All enables are 0 in OFF, IDLE and SWITCH.
- Command mux:
  - Outputs are registered with one-cycle latency from the selected *_cmd.
  - The selected source is that of the current state.
  - In OFF, IDLE and SWITCH all four command outputs are 0.
  - move_fwd and move_bwd both requested in the same cycle -> both outputs 0; the same rule applies to turn_left and turn_right.
- Idle timer, active in powered states:
  - Activity = any bit of the active mode's *_cmd, power_btn=1, or a mode_sel change. On activity the timer clears.
  - Otherwise the timer increments; when it reaches IDLE_TIMEOUT_CYC-1 -> OFF.
  - The timer is held at 0 in OFF.
- Entering OFF, by any cause, clears all counters. Outputs return to 0 on the next edge; the command registers clear in the same edge.
- Reset asserted mid-operation: immediate return to reset values regardless of state or counters.
- Counters saturate; they never wrap.

Test Plan:
All scenarios use LONG_PRESS_CYC=8, IDLE_TIMEOUT_CYC=20, SWITCH_GAP_CYC=2.
1. Reset, then power_btn pulse of 1 cycle -> power=1, ctrl_state=1 next cycle. Holding the button 8 cycles -> power=0 in cycle 8. Continuing to hold 10 more cycles -> stays OFF; release then press -> powers on.
2. Powered, mode_sel 00->01 -> ctrl_state=5 for 2 cycles, then 2 with manual_en=1. man_cmd=4'b1000 -> move_fwd=1 one cycle later, others 0.
3. In MANUAL, mode_sel->11 -> manual_en drops the next cycle, all commands 0 for 2 cycles, then auto_en=1 and move outputs follow auto_cmd. man_cmd toggling in AUTO has no effect.
4. In SEMI, semi_cmd=4'b1111 -> all four motion outputs 0. semi_cmd=4'b1010 -> move_fwd=1, turn_left=1.
5. Powered in MANUAL with all inputs 0 for 20 cycles -> power=0, ctrl_state=0, enables 0. A repeat where man_cmd=4'b0001 is pulsed at cycle 15 -> still powered at cycle 25.
6. rst_n asserted mid-SWITCH with power_btn held -> all outputs 0 immediately (asynchronous). After release of rst_n with power_btn still 1, the system stays OFF until the button is released and pressed again.
